mem_access: RTL and testbench
=============================

# mem_access

Load/store stage of the RV32I core, directly downstream of the execute stage. It takes the ALU result as the effective address, aligns store data and byte enables, and runs a request/grant/response handshake to the data memory. It returns sign- or zero-extended load data and holds `stall` high so the core freezes the current instruction until the access completes. Misaligned accesses, illegal `funct3` encodings and memory timeouts are reported as one-cycle error flags.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in REQ+WAIT before a bus error; 0 disables the timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_en` in 1: current instruction is a load or store.
- `mem_we` in 1: 1 = store, 0 = load.
- `funct3` in 3: RV32I size/sign field.
- `addr` in 32: effective address (ALU result).
- `store_data` in 32: rs2 value.
- `load_data` out 32: formatted load result; valid in the DONE cycle, held until the next capture.
- `stall` out 1: core must hold PC and instruction.
- `align_err` out 1: misaligned or illegal access; valid in the DONE cycle only.
- `bus_err` out 1: timeout; valid in the DONE cycle only.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (bits [1:0] = 0), `dmem_wdata` out 32, `dmem_mask` out 4: request bus.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: load response.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `mem_en`=1 and legal: register `dmem_addr`, `dmem_we`, `dmem_wdata`, `dmem_mask`, `funct3` and `addr[1:0]`, then go to REQ.
  - `mem_en`=1 and illegal: set `align_err`, go to DONE, issue no request.
- **Illegal accesses**
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `funct3` ∈ {011, 110, 111}.
  - Store with `funct3[2]`=1.
- **Store formatting**
  - SB: wdata = {4{data[7:0]}}, mask = 0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, mask = 0011 << {addr[1],0}.
  - SW: wdata = data, mask = 1111.
  - Loads: mask = 1111.
- **REQ**
  - `dmem_req`=1, with request fields stable until `dmem_gnt`.
  - On `gnt` with a store: go to DONE.
  - On `gnt` with a load: go to WAIT.
  - On `gnt` with a load and `rvalid` in the same cycle: capture the data and go directly to DONE.
- **WAIT**
  - On `dmem_rvalid`: capture the data and go to DONE.
- **Load extraction** from `rdata` by the registered `addr[1:0]`:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
- **Timeout**
  - An 8+ bit counter clears on IDLE→REQ and increments each REQ/WAIT cycle.
  - At `TIMEOUT_CYCLES`: go to DONE, `bus_err`=1, `load_data`=0, `dmem_req` drops.
- **DONE**
  - `stall`=0, then go to IDLE on the next edge.
  - The core advances on this edge.
- `stall` = `mem_en` & (state ≠ DONE).
- Inputs are sampled only in IDLE. Changes in `mem_en` after capture do not abort the access.
- `dmem_rvalid` outside WAIT (and outside REQ-with-`gnt`) is ignored.
- Reset behaviour:
  - Async reset forces IDLE; clears `load_data`, the error flags, all `dmem_*` outputs and the counter.
  - `dmem_req` drops immediately, even mid-handshake.

## Timing
- All outputs except `stall` are registered or decoded from state.
- `stall` is combinational from `mem_en` and state.
- **Zero-wait store** (`gnt` in the first REQ cycle):
  - c0 IDLE, c1 REQ, c2 DONE.
  - `stall` high in c0–c1.
- **Load, `rvalid` one cycle after `gnt`:**
  - c0 IDLE, c1 REQ, c2 WAIT, c3 DONE.
  - `load_data` valid in c3.
- **Load, `gnt`+`rvalid` together:** DONE in c2.
- **Illegal access:** DONE in c1, no `dmem_req`.
- **Back-to-back accesses:** min 3 cycles per access (IDLE, REQ, DONE); DONE→IDLE takes no request that cycle.

## Structure
- Package `lsu_pkg`:
  - `funct3` localparams (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - State enum.
  - Default `TIMEOUT_CYCLES`.
- One combinational sub-module, `lsu_format`:
  - Store alignment (wdata/mask).
  - Load extraction/extension.
  - Legality check.
- The FSM, counter and registers live in `mem_access`.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, `gnt` in first REQ cycle → `dmem_addr`=0x100, mask 1111, wdata 0xDEADBEEF; `stall` high 2 cycles.
- SB addr 0x103, data 0x000000A5 → mask 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, `rdata` 0x80FF7F01, `rvalid` 1 cycle after `gnt` → `load_data`=0xFFFFFFFF in DONE (c3).
- LHU addr 0x102, same `rdata` with `gnt`+`rvalid` together → `load_data`=0x000080FF in c2.
- LW addr 0x101 → `align_err`=1 for one cycle, `dmem_req` never asserted, `stall` high 1 cycle.
- `TIMEOUT_CYCLES`=4, `gnt` held low → `bus_err`=1 and `load_data`=0 after 4 REQ cycles.
- Separately, `rst` asserted during WAIT → `dmem_req`=0, state IDLE, outputs cleared asynchronously.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store stage: funct3 encodings,
// FSM state type and the default bus timeout.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_format.sv
// Combinational data path of the load/store stage: access legality,
// store lane replication with byte enables, and load lane extraction.
module lsu_format
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  mask,
  output logic        legal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_LB:   legal = 1'b1;
      F3_LH:   legal = ~addr_lo[0];
      F3_LW:   legal = (addr_lo == 2'b00);
      F3_LBU:  legal = ~we;
      F3_LHU:  legal = ~we & ~addr_lo[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    wdata = store_data;
    mask  = 4'b1111;
    if (we) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          mask  = 4'b0001 << addr_lo;
        end
        F3_SH: begin
          wdata = {2{store_data[15:0]}};
          mask  = 4'b0011 << {addr_lo[1], 1'b0};
        end
        default: begin
          wdata = store_data;
          mask  = 4'b1111;
        end
      endcase
    end
  end

  // Lane selection uses the offset captured with the request, not the live address.
  always_comb begin
    byte_sel = rdata[{ld_addr_lo, 3'b000} +: 8];
    half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_LB:   load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_value = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_value = {24'h000000, byte_sel};
      F3_LHU:  load_value = {16'h0000, half_sel};
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I load/store stage: captures the access in IDLE, runs the data memory
// request/grant/response handshake with a timeout, and returns formatted loads.
module mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mask,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_t       state;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic [31:0]      fmt_wdata;
  logic [3:0]       fmt_mask;
  logic             fmt_legal;
  logic [31:0]      fmt_load;

  lsu_format u_format (
    .we         (mem_we),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .wdata      (fmt_wdata),
    .mask       (fmt_mask),
    .legal      (fmt_legal),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .rdata      (dmem_rdata),
    .load_value (fmt_load)
  );

  assign cnt_inc     = cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT);

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign dmem_req = (state == REQ);
  assign stall    = mem_en & (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_mask  <= '0;
      f3_q       <= '0;
      lo_q       <= '0;
      cnt        <= '0;
      load_data  <= '0;
      align_err  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en) begin
            if (fmt_legal) begin
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_we    <= mem_we;
              dmem_wdata <= fmt_wdata;
              dmem_mask  <= fmt_mask;
              f3_q       <= funct3;
              lo_q       <= addr[1:0];
              cnt        <= '0;
              state      <= REQ;
            end else begin
              align_err <= 1'b1;
              state     <= DONE;
            end
          end
        end

        REQ: begin
          cnt <= cnt_inc;
          if (dmem_gnt) begin
            if (dmem_we) begin
              state <= DONE;
            end else if (dmem_rvalid) begin
              load_data <= fmt_load;
              state     <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (timeout_hit) begin
            bus_err   <= 1'b1;
            load_data <= '0;
            state     <= DONE;
          end
        end

        WAIT: begin
          cnt <= cnt_inc;
          if (dmem_rvalid) begin
            load_data <= fmt_load;
            state     <= DONE;
          end else if (timeout_hit) begin
            bus_err   <= 1'b1;
            load_data <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          align_err <= 1'b0;
          bus_err   <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected transactions are queued when an
// access is launched and compared against what the memory bus and core observe.
module tb_mem_access;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, align_err, bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        aerr;
    logic        berr;
    int          done_cyc;
    int          stall_cyc;
    int          req_cyc;
  } txn_t;

  txn_t sb_q[$];

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .load_data   (load_data),
    .stall       (stall),
    .align_err   (align_err),
    .bus_err     (bus_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_mask   (dmem_mask),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [3:0] m,
                              input logic [31:0] wd, input logic [31:0] ld, input logic ae,
                              input logic be, input int dc, input int sc, input int rc);
    txn_t t;
    t.we = we; t.addr = a; t.mask = m; t.wdata = wd; t.ldata = ld;
    t.aerr = ae; t.berr = be; t.done_cyc = dc; t.stall_cyc = sc; t.req_cyc = rc;
    return t;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == F3_SB) return (lo == 2'd0) ? 4'b0001 : (lo == 2'd1) ? 4'b0010 :
                             (lo == 2'd2) ? 4'b0100 : 4'b1000;
    if (f3 == F3_SH) return lo[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == F3_SB) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3 == F3_SH) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * lo);
    case (f3)
      F3_LB:   return {{24{sh[7]}}, sh[7:0]};
      F3_LBU:  return {24'h0, sh[7:0]};
      F3_LH:   return {{16{sh[15]}}, sh[15:0]};
      F3_LHU:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  // Drives one access as core and memory. gnt_wait: REQ cycles before gnt (-1 never);
  // rv_wait: cycles after the gnt cycle until rvalid (0 = same cycle, -1 never).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int gnt_wait, input int rv_wait,
                        input logic [31:0] rdata, input bit last, output txn_t o);
    int req_n = 0;
    int wait_n = 0;
    bit granted = 0;
    bit done = 0;
    o = mk(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, -1, 0, 0);
    @(negedge clk);
    mem_en = 1'b1; mem_we = we; funct3 = f3; addr = a; store_data = d;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (dmem_req) begin
        if (gnt_wait >= 0 && req_n == gnt_wait) begin
          dmem_gnt = 1'b1;
          granted = 1;
          o.we = dmem_we; o.addr = dmem_addr; o.mask = dmem_mask; o.wdata = dmem_wdata;
          if (!we && rv_wait == 0) begin
            dmem_rvalid = 1'b1;
            dmem_rdata = rdata;
          end
        end
        req_n++;
      end else if (granted && stall) begin
        wait_n++;
        if (wait_n == rv_wait) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = rdata;
        end
      end
      #1;
      if (stall) o.stall_cyc++;
      else begin
        done = 1;
        o.done_cyc = cyc;
        o.ldata = load_data; o.aerr = align_err; o.berr = bus_err;
        if (last) mem_en = 1'b0;
      end
    end
    o.req_cyc = req_n;
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL access_bound: no completion within 100 cycles, addr %h", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #3;
    total++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", dmem_req); else passed++;
    total++; if (load_data !== 32'h0) $display("FAIL reset_load: got %h want 0", load_data); else passed++;
    total++; if ({align_err, bus_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {align_err, bus_err}); else passed++;
    total++; if (dmem_mask !== 4'h0) $display("FAIL reset_mask: got %b want 0000", dmem_mask); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store_word();
    txn_t o, e;
    sb_q.push_back(mk(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, '0, 1'b0, 1'b0, 2, 2, 1));
    access(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, '0, 1, o);
    e = sb_q.pop_front();
    total++; if (o.addr !== e.addr) $display("FAIL sw_addr: got %h want %h", o.addr, e.addr); else passed++;
    total++; if (o.mask !== e.mask) $display("FAIL sw_mask: got %b want %b", o.mask, e.mask); else passed++;
    total++; if (o.wdata !== e.wdata) $display("FAIL sw_wdata: got %h want %h", o.wdata, e.wdata); else passed++;
    total++; if (o.we !== e.we) $display("FAIL sw_we: got %b want %b", o.we, e.we); else passed++;
    total++; if (o.stall_cyc != e.stall_cyc) $display("FAIL sw_stall: got %0d want %0d", o.stall_cyc, e.stall_cyc); else passed++;
    total++; if (o.done_cyc != e.done_cyc) $display("FAIL sw_done: got %0d want %0d", o.done_cyc, e.done_cyc); else passed++;
  endtask

  task automatic test_store_byte();
    txn_t o, e;
    sb_q.push_back(mk(1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5, '0, 1'b0, 1'b0, 2, 2, 1));
    access(1'b1, F3_SB, 32'h103, 32'h000000A5, 0, 0, '0, 1, o);
    e = sb_q.pop_front();
    total++; if (o.addr !== e.addr) $display("FAIL sb_addr: got %h want %h", o.addr, e.addr); else passed++;
    total++; if (o.mask !== e.mask) $display("FAIL sb_mask: got %b want %b", o.mask, e.mask); else passed++;
    total++; if (o.wdata !== e.wdata) $display("FAIL sb_wdata: got %h want %h", o.wdata, e.wdata); else passed++;
    total++; if (o.aerr !== e.aerr) $display("FAIL sb_aerr: got %b want %b", o.aerr, e.aerr); else passed++;
  endtask

  task automatic test_load_byte();
    txn_t o, e;
    sb_q.push_back(mk(1'b0, 32'h100, 4'b1111, '0, 32'hFFFFFFFF, 1'b0, 1'b0, 3, 3, 1));
    access(1'b0, F3_LB, 32'h102, '0, 0, 1, 32'h80FF7F01, 1, o);
    e = sb_q.pop_front();
    total++; if (o.ldata !== e.ldata) $display("FAIL lb_data: got %h want %h", o.ldata, e.ldata); else passed++;
    total++; if (o.done_cyc != e.done_cyc) $display("FAIL lb_done: got %0d want %0d", o.done_cyc, e.done_cyc); else passed++;
    total++; if (o.mask !== e.mask) $display("FAIL lb_mask: got %b want %b", o.mask, e.mask); else passed++;
    total++; if (o.we !== e.we) $display("FAIL lb_we: got %b want %b", o.we, e.we); else passed++;
  endtask

  task automatic test_load_half_fast();
    txn_t o, e;
    sb_q.push_back(mk(1'b0, 32'h100, 4'b1111, '0, 32'h000080FF, 1'b0, 1'b0, 2, 2, 1));
    access(1'b0, F3_LHU, 32'h102, '0, 0, 0, 32'h80FF7F01, 1, o);
    e = sb_q.pop_front();
    total++; if (o.ldata !== e.ldata) $display("FAIL lhu_data: got %h want %h", o.ldata, e.ldata); else passed++;
    total++; if (o.done_cyc != e.done_cyc) $display("FAIL lhu_done: got %0d want %0d", o.done_cyc, e.done_cyc); else passed++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; funct3 = F3_LW; addr = 32'h200; dmem_gnt = 1'b0;
    @(negedge clk);
    dmem_gnt = dmem_req;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    total++; if ({dmem_req, stall} !== 2'b01) $display("FAIL rst_in_wait: req/stall got %b want 01", {dmem_req, stall}); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_wait_req: got %b want 0", dmem_req); else passed++;
    total++; if (load_data !== 32'h0) $display("FAIL rst_wait_load: got %h want 0", load_data); else passed++;
    total++; if (dmem_addr !== 32'h0) $display("FAIL rst_wait_addr: got %h want 0", dmem_addr); else passed++;
    total++; if ({dmem_we, dmem_mask} !== 5'b0) $display("FAIL rst_wait_we_mask: got %b want 00000", {dmem_we, dmem_mask}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if (dmem_req !== 1'b1) $display("FAIL rst_then_req: got %b want 1", dmem_req); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_req_drop: got %b want 0", dmem_req); else passed++;
    mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total++; if (dmem_req !== 1'b0) $display("FAIL rst_idle: got %b want 0", dmem_req); else passed++;
  endtask

  task automatic test_illegal();
    logic [2:0]  f3s [6] = '{F3_LW, F3_LH, 3'b011, 3'b100, F3_SW, 3'b110};
    logic        wes [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] as  [6] = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h102, 32'h0};
    txn_t o, e;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(mk(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1, 1, 0));
      access(wes[i], f3s[i], as[i], 32'h12345678, 0, 0, '0, 1, o);
      e = sb_q.pop_front();
      total++; if (o.aerr !== e.aerr) $display("FAIL illegal%0d_aerr: got %b want %b", i, o.aerr, e.aerr); else passed++;
      total++; if (o.req_cyc != e.req_cyc) $display("FAIL illegal%0d_req: got %0d want %0d", i, o.req_cyc, e.req_cyc); else passed++;
      total++; if (o.done_cyc != e.done_cyc) $display("FAIL illegal%0d_done: got %0d want %0d", i, o.done_cyc, e.done_cyc); else passed++;
      if (i == 0) begin
        @(negedge clk);
        #1;
        total++; if (align_err !== 1'b0) $display("FAIL illegal_pulse: got %b want 0", align_err); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ld_f3 [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    logic [2:0] st_f3 [3] = '{F3_SB, F3_SH, F3_SW};
    logic [31:0] a, d, rd;
    logic [2:0] f3;
    logic we;
    txn_t o, e;
    for (int i = 0; i < 8; i++) begin
      we = $urandom_range(0, 1);
      f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      a = $urandom();
      d = $urandom();
      rd = $urandom();
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      else if (f3[1:0] == 2'b01) a[0] = 1'b0;
      sb_q.push_back(mk(we, {a[31:2], 2'b00}, we ? model_mask(f3, a[1:0]) : 4'b1111,
                        model_wdata(f3, d), model_load(f3, a[1:0], rd), 1'b0, 1'b0, 2, 2, 1));
      access(we, f3, a, d, 0, 0, rd, i == 7, o);
      e = sb_q.pop_front();
      total++; if (o.addr !== e.addr) $display("FAIL b2b%0d_addr: got %h want %h", i, o.addr, e.addr); else passed++;
      total++; if (o.mask !== e.mask) $display("FAIL b2b%0d_mask: got %b want %b", i, o.mask, e.mask); else passed++;
      total++; if (o.done_cyc != e.done_cyc) $display("FAIL b2b%0d_done: got %0d want %0d", i, o.done_cyc, e.done_cyc); else passed++;
      if (we) begin
        total++; if (o.wdata !== e.wdata) $display("FAIL b2b%0d_wdata: got %h want %h", i, o.wdata, e.wdata); else passed++;
      end else begin
        total++; if (o.ldata !== e.ldata) $display("FAIL b2b%0d_load: got %h want %h", i, o.ldata, e.ldata); else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    txn_t o, e;
    access(1'b0, F3_LW, 32'h300, '0, 0, 0, 32'h12345678, 1, o);
    total++; if (o.ldata !== 32'h12345678) $display("FAIL pre_timeout_load: got %h want 12345678", o.ldata); else passed++;
    sb_q.push_back(mk(1'b0, '0, '0, '0, 32'h0, 1'b0, 1'b1, 5, 5, 4));
    access(1'b0, F3_LW, 32'h300, '0, -1, -1, '0, 1, o);
    e = sb_q.pop_front();
    total++; if (o.berr !== e.berr) $display("FAIL timeout_berr: got %b want %b", o.berr, e.berr); else passed++;
    total++; if (o.ldata !== e.ldata) $display("FAIL timeout_load: got %h want %h", o.ldata, e.ldata); else passed++;
    total++; if (o.req_cyc != e.req_cyc) $display("FAIL timeout_req_cycles: got %0d want %0d", o.req_cyc, e.req_cyc); else passed++;
    total++; if (o.done_cyc != e.done_cyc) $display("FAIL timeout_done: got %0d want %0d", o.done_cyc, e.done_cyc); else passed++;
    @(negedge clk);
    #1;
    total++; if ({bus_err, dmem_req} !== 2'b00) $display("FAIL timeout_after: got %b want 00", {bus_err, dmem_req}); else passed++;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_byte();
    test_load_half_fast();
    test_reset_midflight();
    test_illegal();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
